mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU's data memory interface. It accepts `mem_ren`/`mem_wen` requests driven by the CPU datapath and serves them from an internal word-addressed store after a programmable number of wait states. It signals completion with `mem_ack` and holds the CPU with `mem_stall` while the access is in flight. It sits between the datapath's memory port and the top level, replacing the zero-latency data RAM so that the pipeline's stall handling can be exercised.

## Interface
- `ADDR_WIDTH`, 8: word-address bits; store depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 2: wait states per access; legal range 0..15.

Ports:
- `clk` input 1: clock. One clock; everything is on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `mem_ren` input 1: read request from the CPU, held until `mem_ack`.
- `mem_wen` input 1: write request from the CPU, held until `mem_ack`.
- `mem_addr` input 32: byte address; must be word aligned.
- `mem_dout` input 32: write data from the CPU. The name matches the CPU-side port so the two connect one-to-one.
- `mem_din` output 32: read data returned to the CPU.
- `mem_stall` output 1: CPU must hold its request and state.
- `mem_ack` output 1: single-cycle completion pulse.
- `mem_err` output 1: error flag, valid only with `mem_ack`.

## Operation
- FSM states are IDLE, WAIT and DONE. Reset enters IDLE.
- IDLE:
  - When `mem_ren|mem_wen` is high, latch the operation, `mem_addr` and `mem_dout`, and load `wcnt` (4 bits) with `WAIT_CYCLES`.
  - Next state is WAIT, or DONE if `WAIT_CYCLES`==0.
- WAIT: `wcnt` decrements each cycle. When `wcnt`==1, the next state is DONE.
- The access is performed on the edge that enters DONE, using the latched values only:
  - Write: `store[addr[ADDR_WIDTH+1:2]]` <= latched data.
  - Read: `mem_din` <= store word.
- DONE:
  - `mem_ack`=1 for exactly one cycle.
  - Incoming request lines are ignored in this state.
  - Next state is always IDLE.
- Error conditions, evaluated on the latched request:
  - `addr[1:0]`!=0,
  - or `addr[31:ADDR_WIDTH+2]`!=0,
  - or `ren` and `wen` both set.
- On error:
  - No store write takes place.
  - If the request was a read (including the ren+wen case), `mem_din` <= 0.
  - `mem_err`=1 during the DONE cycle.
- `mem_din` holds the last read result until the next read completes. Writes do not change `mem_din`.
- Store contents are not reset; they persist across `rst_n` assertion.

## Timing
- `mem_stall` = (IDLE && (`mem_ren`|`mem_wen`)) || WAIT. It is combinational, so it rises in the same cycle the request appears.
- During DONE, `mem_stall`=0, so the CPU advances on the edge that ends DONE.
- Cycle numbering, with the request first seen in IDLE at cycle T:
  - Cycles T..T+WAIT_CYCLES have `mem_stall`=1.
  - Cycle T+WAIT_CYCLES+1 is DONE: `mem_ack`=1 and `mem_din` is valid.
- Total stall is WAIT_CYCLES+1 cycles.
- Throughput is one access per WAIT_CYCLES+2 cycles, because every request passes through IDLE after DONE.
- Back-to-back requests: a request present in the cycle after DONE is accepted from IDLE normally.
- Request dropped before DONE (protocol violation): the latched access still completes. No retraction is supported.
- Reset while `rst_n` is low:
  - State is IDLE, `wcnt`=0, `mem_din`=0.
  - `mem_stall`, `mem_ack` and `mem_err` are forced to 0.
- Reset mid-operation: if `rst_n` falls before the edge that enters DONE, no write occurs and no ack is issued.
- Release of `rst_n` is synchronised internally (2-flop). The first request is accepted no earlier than 2 edges after release.

## Test plan
- Write then read, `WAIT_CYCLES`=2:
  - Write 0x1234_5678 to 0x0000_0010. Expect stall for 3 cycles, then ack.
  - Read 0x10. Expect `mem_din`=0x1234_5678 on the ack cycle, `mem_err`=0.
- `WAIT_CYCLES`=0: read of word 0x3FC (last word for `ADDR_WIDTH`=8).
  - Expect stall for 1 cycle, then ack.
  - Expect data equal to the value previously written there.
- Misaligned read at 0x0000_0006:
  - Expect `mem_ack`=1, `mem_err`=1, `mem_din`=0.
  - Expect store unchanged (verify with a read of 0x4).
- Out-of-range write to 0x0000_0400:
  - Expect `mem_err`=1.
  - Expect word 0 unchanged, i.e. no aliasing.
- Simultaneous `mem_ren`=`mem_wen`=1: expect error ack, no write, `mem_din`=0.
- Reset mid-operation:
  - Start a write of 0xCAFE_F00D to 0x20 with `WAIT_CYCLES`=3, and pulse `rst_n` low in the first WAIT cycle.
  - Expect no ack and all outputs 0 during reset.
  - Expect the old content at 0x20 to remain.
  - Expect the next request after reset to complete normally.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: wait-state data memory responder for the CPU data port.
// A request seen in IDLE is latched, held for WAIT_CYCLES wait states, then
// performed on the edge that enters DONE, where a one-cycle ack is returned.
module mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_ack,
    output logic        mem_err
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [3:0] WCNT_INIT = 4'(WAIT_CYCLES);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

    logic [1:0]  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] din_q, din_d;
    logic        err_q, err_d;
    logic [1:0]  rst_sync_q, rst_sync_d;

    logic                  ready;
    logic                  req;
    logic                  accept;
    logic                  enter_done;
    logic                  op_ren;
    logic                  op_wen;
    logic                  op_err;
    logic [31:0]           op_addr;
    logic [31:0]           op_data;
    logic [31:0]           rd_word;
    logic [ADDR_WIDTH-1:0] op_idx;
    logic                  store_we;

    // Word store; deliberately not reset so contents survive rst_n.
    logic [31:0] store_mem [DEPTH];

    // Access operands: with zero wait states the access happens on the very
    // edge that latches the request, so the live inputs are the latched values.
    always_comb begin
        req        = mem_ren | mem_wen;
        ready      = rst_sync_q[1];
        rst_sync_d = {rst_sync_q[0], 1'b1};
        accept     = (state_q == ST_IDLE) && req && ready;
        if (state_q == ST_IDLE) begin
            op_ren  = mem_ren;
            op_wen  = mem_wen;
            op_addr = mem_addr;
            op_data = mem_dout;
        end else begin
            op_ren  = ren_q;
            op_wen  = wen_q;
            op_addr = addr_q;
            op_data = data_q;
        end
        op_idx     = op_addr[ADDR_WIDTH+1:2];
        op_err     = (op_addr[1:0] != 2'b00)
                  || (op_addr[31:ADDR_WIDTH+2] != '0)
                  || (op_ren && op_wen);
        enter_done = (accept && ZERO_WAIT)
                  || ((state_q == ST_WAIT) && (wcnt_q == 4'd1));
        store_we   = enter_done && op_wen && !op_err;
        rd_word    = store_mem[op_idx];
    end

    // Next-state, wait counter, request latch and read-data update.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        data_d  = data_q;
        din_d   = din_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ren_d   = mem_ren;
                    wen_d   = mem_wen;
                    addr_d  = mem_addr;
                    data_d  = mem_dout;
                    wcnt_d  = WCNT_INIT;
                    state_d = ZERO_WAIT ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (enter_done) begin
            err_d = op_err;
            if (op_ren) begin
                din_d = op_err ? 32'd0 : rd_word;
            end
        end
    end

    // Control and data registers; a low rst_n aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= 4'd0;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            din_q      <= 32'd0;
            err_q      <= 1'b0;
            rst_sync_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            ren_q      <= ren_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            din_q      <= din_d;
            err_q      <= err_d;
            rst_sync_q <= rst_sync_d;
        end
    end

    // Store write port, only on the edge that enters DONE for a clean write.
    always_ff @(posedge clk) begin
        if (store_we) begin
            store_mem[op_idx] <= op_data;
        end
    end

    assign mem_stall = rst_n & (((state_q == ST_IDLE) & req) | (state_q == ST_WAIT));
    assign mem_ack   = (state_q == ST_DONE);
    assign mem_err   = (state_q == ST_DONE) & err_q;
    assign mem_din   = din_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (2, 0 and 3 wait states) driven by a
// CPU-like request task and checked every cycle against a transaction model.
module tb_mem_responder;

    localparam int NI = 3;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst_n [NI];
    logic        ren   [NI];
    logic        wen   [NI];
    logic [31:0] addr  [NI];
    logic [31:0] wdata [NI];
    logic [31:0] din   [NI];
    logic        stall [NI];
    logic        ack   [NI];
    logic        err   [NI];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance
    bit          busy   [NI];
    int          rem    [NI];
    bit          m_ren  [NI];
    bit          m_wen  [NI];
    logic [31:0] m_addr [NI];
    logic [31:0] m_data [NI];
    logic [31:0] m_din  [NI];
    logic [31:0] m_mem  [NI][256];

    int          ns;
    logic        ae;
    logic [31:0] ad;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            mem_responder #(
                .ADDR_WIDTH (AW),
                .WAIT_CYCLES((gi == 0) ? 2 : ((gi == 1) ? 0 : 3))
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n[gi]),
                .mem_ren  (ren[gi]),
                .mem_wen  (wen[gi]),
                .mem_addr (addr[gi]),
                .mem_dout (wdata[gi]),
                .mem_din  (din[gi]),
                .mem_stall(stall[gi]),
                .mem_ack  (ack[gi]),
                .mem_err  (err[gi])
            );
        end
    endgenerate

    function automatic int wc_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] pool_addr(input int i);
        case (i)
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0004;
            2:       return 32'h0000_0010;
            3:       return 32'h0000_0020;
            4:       return 32'h0000_0044;
            5:       return 32'h0000_0080;
            6:       return 32'h0000_0100;
            default: return 32'h0000_03FC;
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %h expected %h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // Every cycle: derive what each responder must show from the transaction model.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n[k]) begin
                busy[k]  = 1'b0;
                m_din[k] = 32'd0;
                chk("rst_stall", k, {31'd0, stall[k]}, 32'd0);
                chk("rst_ack",   k, {31'd0, ack[k]},   32'd0);
                chk("rst_err",   k, {31'd0, err[k]},   32'd0);
                chk("rst_din",   k, din[k],            32'd0);
            end else if (!busy[k]) begin
                chk("idle_stall", k, {31'd0, stall[k]}, {31'd0, ren[k] | wen[k]});
                chk("idle_ack",   k, {31'd0, ack[k]},   32'd0);
                chk("idle_din",   k, din[k],            m_din[k]);
                if (ren[k] || wen[k]) begin
                    busy[k]   = 1'b1;
                    rem[k]    = wc_of(k);
                    m_ren[k]  = ren[k];
                    m_wen[k]  = wen[k];
                    m_addr[k] = addr[k];
                    m_data[k] = wdata[k];
                end
            end else if (rem[k] > 0) begin
                chk("wait_stall", k, {31'd0, stall[k]}, 32'd1);
                chk("wait_ack",   k, {31'd0, ack[k]},   32'd0);
                chk("wait_din",   k, din[k],            m_din[k]);
                rem[k]--;
            end else begin
                bit e;
                e = (m_addr[k] % 4 != 0) || (m_addr[k] >= 32'h400) || (m_ren[k] && m_wen[k]);
                if (m_wen[k] && !e) m_mem[k][m_addr[k][9:2]] = m_data[k];
                if (m_ren[k]) m_din[k] = e ? 32'd0 : m_mem[k][m_addr[k][9:2]];
                chk("done_ack",   k, {31'd0, ack[k]},   32'd1);
                chk("done_stall", k, {31'd0, stall[k]}, 32'd0);
                chk("done_err",   k, {31'd0, err[k]},   {31'd0, e});
                chk("done_din",   k, din[k],            m_din[k]);
                busy[k] = 1'b0;
            end
        end
    end

    // CPU-side access: hold the request until ack (bounded); returns stall count, err, data.
    task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, output int nstall, output logic e, output logic [31:0] rd);
        bit got;
        ren[k] = r; wen[k] = w; addr[k] = a; wdata[k] = d;
        nstall = 0; got = 1'b0; e = 1'b0; rd = 32'd0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (ack[k]) begin
                got = 1'b1;
                e   = err[k];
                rd  = din[k];
            end else if (stall[k]) begin
                nstall++;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout inst%0d: got no ack expected ack within 40 cycles", k);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < NI; k++) begin
            ren[k] = 1'b0;
            wen[k] = 1'b0;
        end
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300us");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1'b0; ren[k] = 1'b0; wen[k] = 1'b0;
            addr[k] = 32'd0; wdata[k] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
        idle(4);

        // Fill the address pool of every instance with known words
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < 8; p++) begin
                access(k, 1'b0, 1'b1, pool_addr(p), 32'hD000_0000 | (32'(k) << 16) | pool_addr(p), ns, ae, ad);
                idle(0);
            end
        end
        idle(2);

        // Two wait states: write then back-to-back read
        access(0, 1'b0, 1'b1, 32'h10, 32'h1234_5678, ns, ae, ad);
        chk("w2_stall_cycles", 0, 32'(ns), 32'd3);
        chk("w2_write_err", 0, {31'd0, ae}, 32'd0);
        idle(0);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, ns, ae, ad);
        chk("w2_stall_cycles_rd", 0, 32'(ns), 32'd3);
        chk("w2_read_data", 0, ad, 32'h1234_5678);
        chk("w2_read_err", 0, {31'd0, ae}, 32'd0);
        idle(1);

        // Zero wait states: last word of the store
        access(1, 1'b1, 1'b0, 32'h3FC, 32'd0, ns, ae, ad);
        chk("w0_stall_cycles", 1, 32'(ns), 32'd1);
        chk("w0_last_word", 1, ad, 32'hD001_03FC);
        idle(0);
        access(1, 1'b0, 1'b1, 32'h3FC, 32'hA5A5_0FF0, ns, ae, ad);
        idle(1);
        access(1, 1'b1, 1'b0, 32'h3FC, 32'd0, ns, ae, ad);
        chk("w0_last_word_rw", 1, ad, 32'hA5A5_0FF0);
        idle(1);

        // Misaligned read
        access(0, 1'b1, 1'b0, 32'h6, 32'd0, ns, ae, ad);
        chk("misalign_err", 0, {31'd0, ae}, 32'd1);
        chk("misalign_din", 0, ad, 32'd0);
        idle(1);
        access(0, 1'b1, 1'b0, 32'h4, 32'd0, ns, ae, ad);
        chk("misalign_neighbour", 0, ad, 32'hD000_0004);
        idle(1);

        // Out-of-range write must not alias onto word 0
        access(0, 1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF, ns, ae, ad);
        chk("oor_err", 0, {31'd0, ae}, 32'd1);
        idle(1);
        access(0, 1'b1, 1'b0, 32'h0, 32'd0, ns, ae, ad);
        chk("oor_no_alias", 0, ad, 32'hD000_0000);
        idle(1);

        // Read and write together
        access(0, 1'b1, 1'b1, 32'h44, 32'h1111_1111, ns, ae, ad);
        chk("rw_err", 0, {31'd0, ae}, 32'd1);
        chk("rw_din", 0, ad, 32'd0);
        idle(1);
        access(0, 1'b1, 1'b0, 32'h44, 32'd0, ns, ae, ad);
        chk("rw_no_write", 0, ad, 32'hD000_0044);
        idle(1);

        // Reset in the first wait cycle of a three-wait-state write
        ren[2] = 1'b0; wen[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'hCAFE_F00D;
        @(posedge clk);
        #2;
        rst_n[2] = 1'b0;
        wen[2]   = 1'b0;
        #1;
        chk("midrst_stall", 2, {31'd0, stall[2]}, 32'd0);
        chk("midrst_ack",   2, {31'd0, ack[2]},   32'd0);
        chk("midrst_din",   2, din[2],            32'd0);
        @(posedge clk);
        #2;
        rst_n[2] = 1'b1;
        idle(4);
        access(2, 1'b1, 1'b0, 32'h20, 32'd0, ns, ae, ad);
        chk("midrst_old_word", 2, ad, 32'hD002_0020);
        chk("midrst_next_err", 2, {31'd0, ae}, 32'd0);
        chk("midrst_next_stall", 2, 32'(ns), 32'd4);
        idle(1);

        // Randomised traffic across all instances
        for (int i = 0; i < 90; i++) begin
            int          k;
            int          kind;
            bit          r;
            bit          w;
            logic [31:0] a;
            k    = $urandom_range(0, NI - 1);
            kind = $urandom_range(0, 9);
            a    = pool_addr($urandom_range(0, 7));
            r    = 1'b0;
            w    = 1'b0;
            if (kind <= 3) begin
                w = 1'b1;
            end else if (kind <= 7) begin
                r = 1'b1;
            end else if (kind == 8) begin
                a = a + 32'($urandom_range(1, 3));
                r = $urandom_range(0, 1) == 1;
                w = !r;
            end else begin
                a = a | (32'($urandom_range(1, 255)) << 10);
                r = $urandom_range(0, 1) == 1;
                w = $urandom_range(0, 1) == 1 || !r;
            end
            access(k, r, w, a, $urandom, ns, ae, ad);
            idle($urandom_range(0, 2));
        end

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
